// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl_pkg
// Brief    : Shared types and constants for the instruction fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
package inst_fetch_ctrl_pkg;

  // Width of instruction words and fetch addresses.
  localparam int XLEN = 32;

  // Default fetch address after reset and default exception entry address.
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'hbfc00000;
  localparam logic [XLEN-1:0] DEFAULT_EXC_PC   = 32'hbfc00380;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_sel.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_sel
// Brief    : Priority mux choosing the next fetch PC: exception, eret,
//            pending/coincident branch target, sequential, or hold.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_sel
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_PC = DEFAULT_EXC_PC
) (
  input  logic            exc_valid,
  input  logic            eret_valid,
  input  logic [XLEN-1:0] epc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            br_pending,
  input  logic [XLEN-1:0] br_tgt,
  input  logic [XLEN-1:0] pc,
  input  logic            handshake,
  output logic [XLEN-1:0] next_pc,
  output logic            flush
);

  // Flushes win over everything; otherwise a handshake advances the PC,
  // taking the branch target when this handshake is the delay slot.
  always_comb begin
    next_pc = pc;
    flush   = 1'b0;
    if (exc_valid) begin
      next_pc = EXC_PC;
      flush   = 1'b1;
    end else if (eret_valid) begin
      next_pc = epc;
      flush   = 1'b1;
    end else if (handshake) begin
      if (br_pending) begin
        next_pc = br_tgt;
      end else if (br_valid) begin
        next_pc = br_target;
      end else begin
        next_pc = pc + 32'd4;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Brief    : Instruction fetch sequencer over a split address/data SRAM
//            handshake with a one-entry output slot toward decode, delayed
//            branch redirect and immediate exception/eret redirect.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] EXC_PC   = DEFAULT_EXC_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_valid,
  input  logic            eret_valid,
  input  logic [XLEN-1:0] epc,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic            fe_valid,
  output logic [XLEN-1:0] fe_pc,
  output logic [XLEN-1:0] fe_inst,
  input  logic            de_allowin
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_inflight;
  logic            r_br_pending;
  logic [XLEN-1:0] r_br_tgt;
  logic            r_cancel;
  logic            w_handshake;
  logic            w_data_ret;
  logic            w_flush;
  logic [XLEN-1:0] w_next_pc;

  // A new request is only issued when the slot will be free by the time the
  // data returns, so slot plus in-flight never exceeds one instruction.
  assign inst_req    = (r_state == S_REQ) & (~fe_valid | de_allowin);
  assign inst_addr   = r_pc;
  assign w_handshake = inst_req & inst_addr_ok;
  assign w_data_ret  = (r_state == S_WAIT) & inst_data_ok;

  fetch_redirect_sel #(
    .EXC_PC (EXC_PC)
  ) u_redirect_sel (
    .exc_valid  (exc_valid),
    .eret_valid (eret_valid),
    .epc        (epc),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .br_pending (r_br_pending),
    .br_tgt     (r_br_tgt),
    .pc         (r_pc),
    .handshake  (w_handshake),
    .next_pc    (w_next_pc),
    .flush      (w_flush)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: one request outstanding at a time.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ:   if (w_handshake) w_state_nxt = S_WAIT;
      S_WAIT:  if (inst_data_ok) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // PC, branch bookkeeping, response cancel and output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_pc_inflight <= '0;
      r_br_pending  <= 1'b0;
      r_br_tgt      <= '0;
      r_cancel      <= 1'b0;
      fe_valid      <= 1'b0;
      fe_pc         <= '0;
      fe_inst       <= '0;
    end else begin
      if (w_handshake) begin
        r_pc_inflight <= r_pc;
      end
      if (w_handshake | w_flush) begin
        r_pc <= w_next_pc;
      end

      // Any handshake after a branch is its delay slot and consumes it.
      if (w_flush | w_handshake) begin
        r_br_pending <= 1'b0;
      end else if (br_valid) begin
        r_br_pending <= 1'b1;
        r_br_tgt     <= br_target;
      end

      // Cancel the single outstanding response if a flush leaves one in
      // flight; a flush that coincides with the data drops it directly.
      if (w_flush & (((r_state == S_WAIT) & ~inst_data_ok) | w_handshake)) begin
        r_cancel <= 1'b1;
      end else if (w_data_ret) begin
        r_cancel <= 1'b0;
      end

      // A refill takes precedence over the consume in the same cycle.
      if (w_flush) begin
        fe_valid <= 1'b0;
      end else if (w_data_ret & ~r_cancel) begin
        fe_valid <= 1'b1;
        fe_pc    <= r_pc_inflight;
        fe_inst  <= inst_rdata;
      end else if (fe_valid & de_allowin) begin
        fe_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Brief    : Self-checking bench for inst_fetch_ctrl with an SRAM responder,
//            a transaction-level reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_inst;
  logic        de_allowin;

  inst_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .exc_valid    (exc_valid),
    .eret_valid   (eret_valid),
    .epc          (epc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .fe_valid     (fe_valid),
    .fe_pc        (fe_pc),
    .fe_inst      (fe_inst),
    .de_allowin   (de_allowin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Contents of the instruction memory as a function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'ha5a50f0f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Logs of accepted request addresses/cycles and consumed slot PCs.
  logic [31:0] hs_addr_q[$];
  int          hs_cyc_q[$];
  logic [31:0] use_pc_q[$];
  int          cyc_n = 0;

  // SRAM responder configuration and state.
  int          dly = 0;
  logic        s_hs = 1'b0;
  logic [31:0] s_addr = '0;
  logic        sr_pend = 1'b0;
  logic [31:0] sr_addr = '0;
  int          sr_cnt = 0;

  // Reference model state (transaction level).
  bit          m_idle = 1'b1;
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_fv   = 1'b0;
  bit          m_brp  = 1'b0;
  logic [31:0] m_pc   = 32'hbfc00000;
  logic [31:0] m_infl = '0;
  logic [31:0] m_fpc  = '0;
  logic [31:0] m_brt  = '0;

  // SRAM: data returns one cycle after the accepted address plus dly cycles.
  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      sr_pend      = 1'b0;
      inst_data_ok = 1'b0;
    end else begin
      inst_data_ok = 1'b0;
      if (sr_pend) begin
        if (sr_cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_word(sr_addr);
          sr_pend      = 1'b0;
        end else begin
          sr_cnt--;
        end
      end
      if (s_hs) begin
        if (dly == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_word(s_addr);
        end else begin
          sr_pend = 1'b1;
          sr_addr = s_addr;
          sr_cnt  = dly - 1;
        end
      end
    end
  end

  // Every cycle: compare the DUT with the model, log, then advance the model.
  initial forever begin
    bit          exp_req;
    bit          hs;
    bit          flush;
    logic [31:0] tgt;
    @(negedge clk);
    cyc_n++;
    s_hs   = inst_req & inst_addr_ok;
    s_addr = inst_addr;
    if (reset) begin
      chk("rst_req", 32'(inst_req), 32'd0);
      chk("rst_fe_valid", 32'(fe_valid), 32'd0);
      chk("rst_fe_pc", fe_pc, 32'd0);
      chk("rst_fe_inst", fe_inst, 32'd0);
      m_idle = 1'b1; m_busy = 1'b0; m_drop = 1'b0; m_fv = 1'b0; m_brp = 1'b0;
      m_pc   = 32'hbfc00000;
    end else begin
      exp_req = !m_idle && !m_busy && (!m_fv || de_allowin);
      chk("req", 32'(inst_req), 32'(exp_req));
      if (exp_req) chk("addr", inst_addr, m_pc);
      chk("fe_valid", 32'(fe_valid), 32'(m_fv));
      if (m_fv) begin
        chk("fe_pc", fe_pc, m_fpc);
        chk("fe_inst", fe_inst, mem_word(m_fpc));
      end
      if (s_hs) begin
        hs_addr_q.push_back(inst_addr);
        hs_cyc_q.push_back(cyc_n);
      end
      if (fe_valid && de_allowin) use_pc_q.push_back(fe_pc);

      hs    = exp_req && inst_addr_ok;
      flush = exc_valid || eret_valid;
      tgt   = exc_valid ? 32'hbfc00380 : epc;
      m_idle = 1'b0;
      if (m_fv && de_allowin) m_fv = 1'b0;
      if (m_busy && inst_data_ok) begin
        m_busy = 1'b0;
        if (!m_drop && !flush) begin
          m_fv  = 1'b1;
          m_fpc = m_infl;
        end
        m_drop = 1'b0;
      end
      if (hs) begin
        m_busy = 1'b1;
        m_infl = m_pc;
        if (m_brp)         m_pc = m_brt;
        else if (br_valid) m_pc = br_target;
        else               m_pc = m_pc + 32'd4;
        m_brp = 1'b0;
      end else if (br_valid) begin
        m_brp = 1'b1;
        m_brt = br_target;
      end
      if (flush) begin
        m_pc  = tgt;
        m_fv  = 1'b0;
        m_brp = 1'b0;
        if (m_busy) m_drop = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 after release (DUT in IDLE).
  task automatic do_reset();
    reset      = 1'b1;
    br_valid   = 1'b0;
    br_target  = '0;
    exc_valid  = 1'b0;
    eret_valid = 1'b0;
    epc        = '0;
    cyc(3);
    hs_addr_q.delete();
    hs_cyc_q.delete();
    use_pc_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    int n_bad_addr;
    reset        = 1'b1;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    de_allowin   = 1'b1;

    // Sequential fetch, zero-wait SRAM.
    do_reset();
    chk("t1_idle_req", 32'(inst_req), 32'd0);
    cyc(12);
    chk("t1_hs0", hs_addr_q[0], 32'hbfc00000);
    chk("t1_hs1", hs_addr_q[1], 32'hbfc00004);
    chk("t1_hs2", hs_addr_q[2], 32'hbfc00008);
    chk("t1_gap0", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd2);
    chk("t1_gap1", 32'(hs_cyc_q[2] - hs_cyc_q[1]), 32'd2);
    chk("t1_use0", use_pc_q[0], 32'hbfc00000);
    chk("t1_use2", use_pc_q[2], 32'hbfc00008);

    // Decode stall holds the slot and blocks requests.
    de_allowin = 1'b0;
    do_reset();
    cyc(8);
    chk("t2_req_stall", 32'(inst_req), 32'd0);
    chk("t2_fe_valid", 32'(fe_valid), 32'd1);
    chk("t2_fe_pc", fe_pc, 32'hbfc00000);
    chk("t2_fe_inst", fe_inst, mem_word(32'hbfc00000));
    chk("t2_nreq", 32'(hs_addr_q.size()), 32'd1);
    de_allowin = 1'b1;
    #1;
    chk("t2_req_release", 32'(inst_req), 32'd1);
    chk("t2_addr_release", inst_addr, 32'hbfc00004);
    cyc(4);

    // Branch coinciding with the delay-slot handshake.
    do_reset();
    cyc(7);
    chk("t3_slot", fe_pc, 32'hbfc00008);
    br_valid  = 1'b1;
    br_target = 32'hbfc00100;
    cyc(1);
    br_valid = 1'b0;
    cyc(6);
    chk("t3_hs3", hs_addr_q[3], 32'hbfc0000c);
    chk("t3_hs4", hs_addr_q[4], 32'hbfc00100);
    chk("t3_hs5", hs_addr_q[5], 32'hbfc00104);
    chk("t3_use3", use_pc_q[3], 32'hbfc0000c);
    chk("t3_use4", use_pc_q[4], 32'hbfc00100);

    // Branch latched while waiting, applied at the next handshake.
    do_reset();
    cyc(2);
    br_valid  = 1'b1;
    br_target = 32'hbfc00200;
    cyc(1);
    br_valid = 1'b0;
    cyc(6);
    chk("t3b_hs1", hs_addr_q[1], 32'hbfc00004);
    chk("t3b_hs2", hs_addr_q[2], 32'hbfc00200);

    // Exception during WAIT with slow data: response dropped.
    dly = 3;
    do_reset();
    cyc(2);
    exc_valid = 1'b1;
    cyc(1);
    exc_valid = 1'b0;
    cyc(2);
    chk("t4_fe_valid_c5", 32'(fe_valid), 32'd0);
    cyc(1);
    chk("t4_fe_valid_c6", 32'(fe_valid), 32'd0);
    chk("t4_req_c6", 32'(inst_req), 32'd1);
    chk("t4_addr_c6", inst_addr, 32'hbfc00380);
    cyc(7);
    chk("t4_hs1", hs_addr_q[1], 32'hbfc00380);
    chk("t4_use0", use_pc_q[0], 32'hbfc00380);
    dly = 0;

    // Exception + eret + branch together: exception wins.
    do_reset();
    cyc(3);
    exc_valid  = 1'b1;
    eret_valid = 1'b1;
    epc        = 32'h80001000;
    br_valid   = 1'b1;
    br_target  = 32'hbfc00100;
    cyc(1);
    exc_valid  = 1'b0;
    eret_valid = 1'b0;
    br_valid   = 1'b0;
    cyc(8);
    chk("t5_hs2", hs_addr_q[2], 32'hbfc00380);
    chk("t5_hs3", hs_addr_q[3], 32'hbfc00384);
    chk("t5_use1", use_pc_q[1], 32'hbfc00380);
    n_bad_addr = 0;
    foreach (hs_addr_q[i])
      if (hs_addr_q[i] == 32'h80001000 || hs_addr_q[i] == 32'hbfc00100) n_bad_addr++;
    chk("t5_no_stray", 32'(n_bad_addr), 32'd0);

    // Eret + branch together: eret wins, branch ignored.
    do_reset();
    cyc(3);
    eret_valid = 1'b1;
    epc        = 32'h80001000;
    br_valid   = 1'b1;
    br_target  = 32'hbfc00100;
    cyc(1);
    eret_valid = 1'b0;
    br_valid   = 1'b0;
    cyc(6);
    chk("t6_hs2", hs_addr_q[2], 32'h80001000);
    chk("t6_hs3", hs_addr_q[3], 32'h80001004);

    // Asynchronous reset while waiting for data.
    do_reset();
    cyc(4);
    reset = 1'b1;
    #1;
    chk("t7_req", 32'(inst_req), 32'd0);
    chk("t7_fe_valid", 32'(fe_valid), 32'd0);
    chk("t7_fe_pc", fe_pc, 32'd0);
    chk("t7_fe_inst", fe_inst, 32'd0);
    cyc(2);
    reset = 1'b0;
    #1;
    chk("t7_idle_req", 32'(inst_req), 32'd0);
    cyc(1);
    chk("t7_first_req", 32'(inst_req), 32'd1);
    chk("t7_first_addr", inst_addr, 32'hbfc00000);
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
